// File: rtl/conv3_dw_pkg.sv
// Shared constants, pixel/window types and the channel-major window packing
// used by the 3x3 depthwise sliding-window generator.
package conv3_dw_pkg;

  localparam int CH    = 16;
  localparam int DW    = 16;
  localparam int KTAPS = 9;
  localparam int PIX_W = CH * DW;
  localparam int WIN_W = CH * KTAPS * DW;

  typedef logic [PIX_W-1:0] pixel_t;
  // Indexed [dy][dx]; dy=0 is the oldest row, dx=0 the leftmost column.
  typedef logic [2:0][2:0][PIX_W-1:0] window_t;

  function automatic logic [WIN_W-1:0] pack_window(input window_t win);
    logic [WIN_W-1:0] flat;
    flat = '0;
    for (int k = 0; k < CH; k++) begin
      for (int t = 0; t < KTAPS; t++) begin
        flat[k*KTAPS*DW + t*DW +: DW] = win[t/3][t%3][k*DW +: DW];
      end
    end
    return flat;
  endfunction

endpackage

// File: rtl/conv3_dw_window_if.sv
// Stream interface of the sliding-window generator. The win_count signal
// exists only when CONV3_DW_WIN_PERF_EN is defined.
interface conv3_dw_window_if;
  import conv3_dw_pkg::*;

  logic             valid;
  pixel_t           input_act;
  logic [WIN_W-1:0] output_act;
  logic             ready;
  logic             frame_done;
`ifdef CONV3_DW_WIN_PERF_EN
  logic [15:0]      win_count;

  modport master (output valid, input_act,
                  input  output_act, ready, frame_done, win_count);
  modport slave  (input  valid, input_act,
                  output output_act, ready, frame_done, win_count);
`else
  modport master (output valid, input_act,
                  input  output_act, ready, frame_done);
  modport slave  (input  valid, input_act,
                  output output_act, ready, frame_done);
`endif

endinterface

// File: rtl/conv3_dw_line_buffer.sv
// One W-deep pixel line buffer: combinational read and registered write at
// the same address, so a cycle reads the old contents before overwriting.
module conv3_dw_line_buffer
  import conv3_dw_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [$clog2(W)-1:0] addr,
  input  pixel_t               wdata,
  output pixel_t               rdata
);

  pixel_t mem [W];

  assign rdata = mem[addr];

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv3_dw_window.sv
// 3x3 sliding-window generator (stride 1, no padding) feeding the depthwise
// stage. Define CONV3_DW_WIN_PERF_EN to add the win_count perf counter.
module conv3_dw_window
  import conv3_dw_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 16
) (
  input logic              clk,
  input logic              rstn,
  conv3_dw_window_if.slave bus
);

  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0]    col_r;
  logic [RW-1:0]    row_r;
  pixel_t           lb0_rd_s;
  pixel_t           lb1_rd_s;
  window_t          win_r;
  window_t          win_next_s;
  logic             emit_s;
  logic             last_s;
  logic [WIN_W-1:0] output_act_r;
  logic             ready_r;
  logic             frame_done_r;

  // LB1 holds row r-1, LB0 holds row r-2; LB1's old entry cascades into LB0.
  conv3_dw_line_buffer #(.W(W)) u_lb0 (
    .clk   (clk),
    .wr_en (bus.valid),
    .addr  (col_r),
    .wdata (lb1_rd_s),
    .rdata (lb0_rd_s)
  );

  conv3_dw_line_buffer #(.W(W)) u_lb1 (
    .clk   (clk),
    .wr_en (bus.valid),
    .addr  (col_r),
    .wdata (bus.input_act),
    .rdata (lb1_rd_s)
  );

  assign emit_s = bus.valid && (row_r >= ROW_MIN) && (col_r >= COL_MIN);
  assign last_s = (row_r == ROW_LAST) && (col_r == COL_LAST);

  // Next window: shift left one column and load the fresh right column.
  always_comb begin
    win_next_s = win_r;
    if (bus.valid) begin
      win_next_s[0][0] = win_r[0][1];
      win_next_s[0][1] = win_r[0][2];
      win_next_s[1][0] = win_r[1][1];
      win_next_s[1][1] = win_r[1][2];
      win_next_s[2][0] = win_r[2][1];
      win_next_s[2][1] = win_r[2][2];
      win_next_s[0][2] = lb0_rd_s;
      win_next_s[1][2] = lb1_rd_s;
      win_next_s[2][2] = bus.input_act;
    end else begin
      win_next_s = win_r;
    end
  end

  // Raster position of the next pixel; wraps at frame end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_r <= '0;
      row_r <= '0;
    end else if (bus.valid) begin
      if (col_r == COL_LAST) begin
        col_r <= '0;
        row_r <= (row_r == ROW_LAST) ? '0 : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
      end
    end
  end

  // Window register and registered outputs; output_act holds between windows.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_r        <= '0;
      output_act_r <= '0;
      ready_r      <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      win_r        <= win_next_s;
      ready_r      <= emit_s;
      frame_done_r <= emit_s && last_s;
      if (emit_s) begin
        output_act_r <= pack_window(win_next_s);
      end
    end
  end

  assign bus.output_act = output_act_r;
  assign bus.ready      = ready_r;
  assign bus.frame_done = frame_done_r;

`ifdef CONV3_DW_WIN_PERF_EN
  logic [15:0] win_count_r;

  // Counts emitted windows; advances on the same edge that raises ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_count_r <= 16'd0;
    end else if (emit_s) begin
      win_count_r <= win_count_r + 16'd1;
    end
  end

  assign bus.win_count = win_count_r;
`endif

endmodule
